// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/response slice.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_LATENCY = 4;
    localparam int ALU_DEPTH   = 4;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_ADD  = 1'b1;

    typedef struct packed {
        logic                 op;
        logic [ALU_WIDTH-1:0] data;
    } alu_resp_t;

    typedef struct packed {
        logic valid;
        logic op;
    } alu_tag_t;

endpackage

// File: rtl/alu_issue_if.sv
// Request, ALU-side and response signals of the issue stage.
interface alu_issue_if #(parameter int WIDTH = 32);

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_in0;
    logic [WIDTH-1:0] req_in1;
    logic             req_op;

    logic [WIDTH-1:0] alu_in0;
    logic [WIDTH-1:0] alu_in1;
    logic             alu_opsel;
    logic [WIDTH-1:0] alu_out;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_op;

    modport slave (
        input  req_valid, req_in0, req_in1, req_op, alu_out, resp_ready,
        output req_ready, alu_in0, alu_in1, alu_opsel, resp_valid, resp_data, resp_op
    );

    modport master (
        output req_valid, req_in0, req_in1, req_op, alu_out, resp_ready,
        input  req_ready, alu_in0, alu_in1, alu_opsel, resp_valid, resp_data, resp_op
    );

endinterface

// File: rtl/alu_resp_fifo.sv
// Synchronous circular FIFO; head is presented combinationally, zero when empty.
module alu_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= next_ptr(wr_ptr);
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            if (push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !push) count <= count - CW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the empty flag masks stale
    // contents, so only pointers and count need a reset value.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage for a fixed-latency add/mult ALU: operand drive, tag pipeline,
// credit counter and in-order response FIFO.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int LATENCY = ALU_LATENCY,
    parameter int DEPTH   = ALU_DEPTH
) (
    input logic        clk,
    input logic        reset,
    alu_issue_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          fire;
    logic          pop;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_d;
    alu_tag_t      tag_q [LATENCY];
    alu_tag_t      tag_last;
    alu_resp_t     push_entry;
    alu_resp_t     head_entry;
    logic          fifo_full;
    logic          fifo_empty;

    // Ready depends only on the credit register, never on req_valid/resp_ready.
    assign bus.req_ready = (outstanding < CW'(DEPTH));
    assign fire          = bus.req_valid & bus.req_ready;
    assign pop           = bus.resp_valid & bus.resp_ready;

    assign bus.alu_in0 = fire ? bus.req_in0 : '0;
    assign bus.alu_in1 = fire ? bus.req_in1 : '0;

    assign tag_last      = tag_q[LATENCY-1];
    assign bus.alu_opsel = tag_last.valid & tag_last.op;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // shifts from its pre-edge value, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: fire, op: bus.req_op};
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // NOTE: default assigned first so no path through this block leaves
    // outstanding_d unassigned and infers a latch.
    always_comb begin
        outstanding_d = outstanding;
        if (fire && !pop)      outstanding_d = outstanding + CW'(1);
        else if (pop && !fire) outstanding_d = outstanding - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) outstanding <= '0;
        else       outstanding <= outstanding_d;
    end

    assign push_entry = '{op: tag_last.op, data: bus.alu_out};

    alu_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(alu_resp_t))
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tag_last.valid),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.resp_valid = ~fifo_empty;
    assign bus.resp_data  = head_entry.data;
    assign bus.resp_op    = head_entry.op;

    // Credits guarantee a result always has a slot unless the head leaves too.
    push_into_full: assert property (@(posedge clk) disable iff (reset)
        !(tag_last.valid && fifo_full && !pop));

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue with a behavioural fixed-latency ALU model.
module tb_alu_issue;
    import alu_pkg::*;

    localparam int W     = ALU_WIDTH;
    localparam int LAT   = ALU_LATENCY;
    localparam int DEPTH = ALU_DEPTH;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int n_vectors     = 0;
    int n_miscompares = 0;

    alu_issue_if #(.WIDTH(W)) bus ();

    alu_issue #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ALU: operands delayed LATENCY cycles, output selected by alu_opsel.
    logic [W-1:0] a_pipe [LAT];
    logic [W-1:0] b_pipe [LAT];
    always @(posedge clk) begin
        a_pipe[0] <= bus.alu_in0;
        b_pipe[0] <= bus.alu_in1;
        for (int i = 1; i < LAT; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
        end
    end
    assign bus.alu_out = bus.alu_opsel ? W'(a_pipe[LAT-1] + b_pipe[LAT-1])
                                       : W'(a_pipe[LAT-1] * b_pipe[LAT-1]);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every accepted request yields op ? a+b : a*b (mod 2^W), in
    // order, visible no earlier than LAT+1 cycles after acceptance.
    typedef struct {
        logic [W-1:0] data;
        logic         op;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    logic issue_op [int];
    int   cyc     = 0;
    int   rst_cnt = 0;

    always @(negedge clk) begin
        logic         fire, pop, exp_valid, exp_opsel;
        logic [W-1:0] a, b;
        cyc++;
        if (reset) begin
            exp_q.delete();
            issue_op.delete();
            if (rst_cnt > 0) begin
                check("rst_resp_valid", bus.resp_valid, 1'b0);
                check("rst_resp_data",  bus.resp_data, '0);
                check("rst_resp_op",    bus.resp_op, 1'b0);
                check("rst_req_ready",  bus.req_ready, 1'b1);
                check("rst_alu_opsel",  bus.alu_opsel, 1'b0);
                check("rst_alu_in0",    bus.alu_in0, '0);
            end
            rst_cnt++;
        end else begin
            rst_cnt   = 0;
            fire      = bus.req_valid & bus.req_ready;
            pop       = bus.resp_valid & bus.resp_ready;
            exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + LAT + 1);
            check("req_ready", bus.req_ready, exp_q.size() < DEPTH);
            check("resp_valid", bus.resp_valid, exp_valid);
            if (exp_valid) begin
                check("resp_data", bus.resp_data, exp_q[0].data);
                check("resp_op",   bus.resp_op,   exp_q[0].op);
            end
            exp_opsel = issue_op.exists(cyc - LAT) ? issue_op[cyc - LAT] : 1'b0;
            if (issue_op.exists(cyc - LAT)) issue_op.delete(cyc - LAT);
            check("alu_opsel", bus.alu_opsel, exp_opsel);
            check("alu_in0", bus.alu_in0, fire ? bus.req_in0 : '0);
            check("alu_in1", bus.alu_in1, fire ? bus.req_in1 : '0);
            if (pop && exp_valid) void'(exp_q.pop_front());
            if (fire) begin
                a = bus.req_in0;
                b = bus.req_in1;
                exp_q.push_back('{data: (bus.req_op == OP_ADD) ? W'(a + b) : W'(a * b),
                                  op: bus.req_op, cyc: cyc});
                issue_op[cyc] = bus.req_op;
            end
        end
    end

    // Called right after a rising edge; returns right after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int waited = 0;
        bus.req_valid = 1'b1;
        bus.req_in0   = a;
        bus.req_in1   = b;
        bus.req_op    = op;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            waited++;
            if (waited > 50) begin
                n_vectors++;
                n_miscompares++;
                $display("FAIL issue_timeout: req_ready stuck at %0b for %0d cycles", bus.req_ready, waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        bus.req_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic fired;
        bus.req_valid  = 1'b0;
        bus.req_in0    = '0;
        bus.req_in1    = '0;
        bus.req_op     = OP_MULT;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        apply_reset(3);

        // Single add, then single mult.
        issue(32'd3, 32'd4, OP_ADD);
        wait_idle();
        issue(32'd6, 32'd7, OP_MULT);
        wait_idle();

        // Back-to-back stream hits the credit limit.
        issue(32'd1, 32'd1, OP_ADD);
        issue(32'd2, 32'd3, OP_MULT);
        issue(32'd5, 32'd5, OP_ADD);
        issue(32'd4, 32'd4, OP_MULT);
        wait_idle();

        // Backpressure: four fill the FIFO, two more wait for the drain.
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(W'(10 * i), W'(i + 1), OP_ADD);
        fork
            begin
                issue(32'd100, 32'd1, OP_ADD);
                issue(32'd200, 32'd2, OP_ADD);
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                bus.resp_ready = 1'b1;
            end
        join
        wait_idle();

        // Reset while two requests are in flight.
        issue(32'd9, 32'd9, OP_ADD);
        issue(32'd8, 32'd8, OP_MULT);
        apply_reset(2);
        repeat (10) @(posedge clk);
        #1;

        // Wrap-around of the ALU arithmetic.
        issue(32'hFFFF_FFFF, 32'h1, OP_ADD);
        issue(32'h0001_0000, 32'h0001_0000, OP_MULT);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULT);
        wait_idle();

        // Random traffic with random backpressure; requests are held until taken.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            fired = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            if (!bus.req_valid || fired) begin
                bus.req_valid = ($urandom_range(0, 3) != 0);
                bus.req_in0   = ($urandom_range(0, 1) != 0) ? W'($urandom()) : W'($urandom_range(0, 15));
                bus.req_in1   = ($urandom_range(0, 1) != 0) ? W'($urandom()) : W'($urandom_range(0, 15));
                bus.req_op    = 1'($urandom_range(0, 1));
            end
            bus.resp_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Issue/response stage directly upstream of the fixed-latency add/mult ALU.
- Accepts valid/ready requests (two operands plus an op select) and drives the ALU operand inputs.
- Carries valid and op tags alongside the ALU pipeline and drives the ALU's output select at result time.
- Captures results into a credit-protected response FIFO with valid/ready backpressure. Results are never dropped.

Parameters:
LATENCY, 4, cycles from operands presented on alu_in0/alu_in1 to result on alu_out; identical for add and mult
WIDTH, 32, operand/result width
DEPTH, 4, response FIFO entries; also the total outstanding-request credit limit

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high with req_valid
req_in0  in  WIDTH  operand 0
req_in1  in  WIDTH  operand 1
req_op  in  1  1 = add, 0 = mult
alu_in0  out  WIDTH  to ALU in0
alu_in1  out  WIDTH  to ALU in1
alu_opsel  out  1  to ALU opsel
alu_out  in  WIDTH  ALU result
resp_valid  out  1  FIFO head valid
resp_ready  in  1  consumer takes head when high with resp_valid
resp_data  out  WIDTH  result at FIFO head
resp_op  out  1  op of result at FIFO head

Behaviour:
- Clock and reset: clk rising edge; reset is synchronous, active-high.
- Issue condition: fire = req_valid & req_ready in cycle t.
- Operand drive:
  - alu_in0/alu_in1 = req_in0/req_in1 combinationally when fire.
  - 0 when not firing.
- Tag pipeline: LATENCY-stage shift register of {valid, op}.
  - Stage 0 loads {fire, req_op}.
  - The last stage corresponds to the ALU result visible in cycle t+LATENCY.
- alu_opsel = op of the last tag stage, combinational. It drives 0 when the last stage is invalid.
- Capture: when the last tag stage is valid, push {alu_out, op} into the FIFO at the end of cycle t+LATENCY.
  - The entry is visible at the head from cycle t+LATENCY+1 at the earliest.
  - Minimum request-to-resp_valid latency is LATENCY+1 = 5 cycles.
- Credits:
  - Counter outstanding, range 0..DEPTH: +1 on fire, -1 on pop (resp_valid & resp_ready).
  - Net change is 0 when fire and pop occur in the same cycle.
  - req_ready = (outstanding < DEPTH), registered-state based only, with no combinational path from req_valid or resp_ready.
- FIFO:
  - DEPTH entries, circular read/write pointers that wrap at DEPTH.
  - resp_valid = not empty; resp_data/resp_op are the head entry; no bypass.
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - The credit rule guarantees a push never finds the FIFO full without a concurrent pop. A push into a full FIFO without a pop is a design error; flag it with an assertion.
- Ordering: strictly in order, because latency is fixed and identical for both ops.
- Arithmetic: none in this block; results are passed as produced (ALU truncates to WIDTH).
- Reset: all tag stages invalid, FIFO empty, outstanding = 0. Output values during reset:
  - req_ready = 1 (the cycle after reset deasserts)
  - resp_valid = 0
  - resp_data = 0, resp_op = 0
  - alu_in0 = alu_in1 = 0, alu_opsel = 0
- Reset mid-operation discards all in-flight and buffered results. ALU-internal pipeline contents returning after reset are ignored because the tags were cleared.
- req_valid while req_ready is low: no issue; the requester holds its request.

Decomposition:
- Shared package alu_pkg:
  - OP_MULT = 1'b0, OP_ADD = 1'b1
  - ALU_LATENCY = 4
  - Packed struct alu_resp_t {op, data[WIDTH]}
- Sub-module alu_resp_fifo: parameterised DEPTH/WIDTH synchronous FIFO with push/pop/full/empty.
- Tag pipeline and credit counter stay in alu_issue.

Test Plan:
1. Single add: reset, then cycle 0 req 3+4 op=1, resp_ready=1 -> resp_valid first high in cycle 5, resp_data=7, resp_op=1; alu_opsel=1 in cycle 4.
2. Single mult: 6*7 op=0 -> cycle 5 resp_data=42, resp_op=0; alu_opsel=0 in cycle 4.
3. Streaming, resp_ready=1: cycles 0-3 issue add 1+1, mult 2*3, add 5+5, mult 4*4 -> req_ready low in cycles 4-5, high again in cycle 6; responses 2, 6, 10, 16 in order in cycles 5-8.
4. Backpressure: resp_ready=0, req_valid held with 6 distinct adds -> exactly 4 accepted; req_ready stays 0 and FIFO holds 4. Then resp_ready=1 -> 4 results drain in order, then remaining 2 accepted and returned.
5. Reset mid-flight: issue 2 requests in cycles 0-1, assert reset in cycle 2 -> resp_valid never asserts for them; req_ready=1 after reset, outstanding=0.
6. Wrap-around: add 0xFFFFFFFF+1 -> 0x00000000; mult 0x00010000*0x00010000 -> 0x00000000; mult 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
